// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain FSM states, default
// data width and a constant-evaluable ceiling log2.
package uart_pkg;

  localparam int unsigned L_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    START = 3'b010,
    WAIT  = 3'b011,
    GAP   = 3'b100
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; one extra pointer bit separates full from empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned L     = L_DEFAULT,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [L-1:0]  wr_data,
  input  logic          rd,
  output logic [L-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [L-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_wr;
  logic         do_rd;

  // full/empty come from the registered pointers, so a same-cycle pop never frees room for a write
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; clearing the pointers is what discards the contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rptr[AW-1:0]];
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue in front of the UART transmitter: buffers producer writes and
// drains them one frame at a time over the i_we/o_busy handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int unsigned L     = L_DEFAULT,
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned TO    = 1024,
  localparam int unsigned CW    = clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [L-1:0]  i_wr_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_overflow,
  input  logic          i_tx_busy,
  output logic          o_tx_we,
  output logic [L-1:0]  o_tx_data,
  output logic          o_active
);

  localparam int unsigned    WW      = clog2(TO) + 1;
  localparam logic [WW-1:0]  WD_LAST = WW'(TO - 1);

  state_t        state;
  logic [WW-1:0] wd_cnt;
  logic [L-1:0]  head;
  logic          pop;

  // The head leaves the queue only once the transmitter has visibly taken it.
  assign pop = (state == START) && i_tx_busy;

  uart_sync_fifo #(
    .L     (L),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr      (i_wr),
    .wr_data (i_wr_data),
    .rd      (pop),
    .rd_data (head),
    .full    (o_full),
    .empty   (o_empty),
    .count   (o_count)
  );

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      o_tx_we   <= 1'b0;
      o_tx_data <= '0;
      wd_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_tx_we <= 1'b0;
          if (!o_empty) state <= LOAD;
        end
        LOAD: begin
          o_tx_data <= head;
          o_tx_we   <= 1'b1;
          wd_cnt    <= '0;
          state     <= START;
        end
        START: begin
          if (i_tx_busy) begin
            state <= WAIT;
          end else if (wd_cnt == WD_LAST) begin
            // Transmitter never answered: keep the byte queued and retry from IDLE.
            o_tx_we <= 1'b0;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (!i_tx_busy) begin
            o_tx_we <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          o_tx_we <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_overflow <= 1'b0;
    else       o_overflow <= i_wr && o_full;
  end

  assign o_active = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model, transmitter model
// that starts a frame on a fresh i_we, directed scenarios plus random traffic.
module tb_uart_tx_feeder;
  localparam int L     = 8;
  localparam int DEPTH = 16;
  localparam int TO    = 1024;
  localparam int D     = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_wr;
  logic [L-1:0]  i_wr_data;
  logic          o_full, o_empty, o_overflow, o_tx_we, o_active;
  logic [CW-1:0] o_count;
  logic [L-1:0]  o_tx_data;
  logic          tx_busy;

  logic hold, dead;
  logic m_busy, armed;
  int   m_cnt;
  logic [L-1:0] line[$];

  logic [L-1:0] mq[$];
  logic m_ovf, popped;
  int   n_pops;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 i_clk = ~i_clk;

  uart_tx_feeder #(.L(L), .DEPTH(DEPTH), .TO(TO)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr       (i_wr),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .i_tx_busy  (tx_busy),
    .o_tx_we    (o_tx_we),
    .o_tx_data  (o_tx_data),
    .o_active   (o_active)
  );

  assign tx_busy = hold ? 1'b1 : (dead ? 1'b0 : m_busy);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter: takes a byte only on a fresh i_we, busy for D cycles, logs it as a frame.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      armed  <= 1'b0;
    end else begin
      if (m_busy) begin
        if (m_cnt == 1) m_busy <= 1'b0;
        m_cnt <= m_cnt - 1;
      end else if (o_tx_we && armed && !hold && !dead) begin
        m_busy <= 1'b1;
        m_cnt  <= D;
        line.push_back(o_tx_data);
        armed  <= 1'b0;
      end
      if (hold)          armed <= 1'b0;
      else if (!o_tx_we) armed <= 1'b1;
    end
  end

  // Reference model: a plain queue. At each falling edge compare the flags with
  // the queue, then apply what the coming rising edge does (accept, pop, push).
  always @(negedge i_clk) begin
    logic accept;
    if (i_rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      popped = 1'b0;
      check("rst_count", 32'(o_count), 0);
      check("rst_empty", 32'(o_empty), 1);
      check("rst_tx_we", 32'(o_tx_we), 0);
      check("rst_active", 32'(o_active), 0);
    end else begin
      check("count", 32'(o_count), mq.size());
      check("full", 32'(o_full), 32'(mq.size() == DEPTH));
      check("empty", 32'(o_empty), 32'(mq.size() == 0));
      check("overflow", 32'(o_overflow), 32'(m_ovf));
      accept = i_wr && (mq.size() < DEPTH);
      m_ovf  = i_wr && !accept;
      if (o_tx_we && tx_busy && !popped) begin
        check("pop_nonempty", 32'(mq.size() != 0), 1);
        if (mq.size() != 0) begin
          check("tx_data", 32'(o_tx_data), 32'(mq[0]));
          void'(mq.pop_front());
          n_pops++;
        end
        popped = 1'b1;
      end
      if (!o_tx_we) popped = 1'b0;
      if (accept) mq.push_back(i_wr_data);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_byte(input logic [L-1:0] b);
    i_wr = 1'b1;
    i_wr_data = b;
    tick();
    i_wr = 1'b0;
  endtask

  task automatic wait_idle(output int peak);
    int n;
    n = 0;
    peak = o_count;
    while (!(o_empty && !o_active && !tx_busy) && n < 3000) begin
      tick();
      if (int'(o_count) > peak) peak = o_count;
      n++;
    end
    check("idle_reached", 32'(n < 3000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int peak, n, run, l0, p0, ovf_cnt, pulses;
    i_rst = 1'b1; i_wr = 1'b0; i_wr_data = '0; hold = 1'b0; dead = 1'b0;
    n_pops = 0;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    check("reset_tx_data", 32'(o_tx_data), 0);
    check("reset_overflow", 32'(o_overflow), 0);

    // 1: single byte, latency and single frame
    write_byte(8'h61);
    check("t1_empty_after_n", 32'(o_empty), 0);
    check("t1_we_n", 32'(o_tx_we), 0);
    tick();
    check("t1_we_n1", 32'(o_tx_we), 0);
    check("t1_active_load", 32'(o_active), 1);
    tick();
    check("t1_we_n2", 32'(o_tx_we), 1);
    check("t1_data_n2", 32'(o_tx_data), 32'h61);
    n = 0;
    while (o_count != 0 && n < 20) begin tick(); n++; end
    check("t1_count_zero", 32'(o_count), 0);
    check("t1_busy_at_pop", 32'(tx_busy), 1);
    wait_idle(peak);
    check("t1_frames", line.size(), 1);
    if (line.size() >= 1) check("t1_frame0", 32'(line[0]), 32'h61);

    // 2: burst "abc"
    l0 = line.size();
    write_byte(8'h61); write_byte(8'h62); write_byte(8'h63);
    wait_idle(peak);
    check("t2_peak", peak, 3);
    check("t2_frames", line.size() - l0, 3);
    if (line.size() == l0 + 3) begin
      check("t2_a", 32'(line[l0]), 32'h61);
      check("t2_b", 32'(line[l0+1]), 32'h62);
      check("t2_c", 32'(line[l0+2]), 32'h63);
    end

    // 3: overflow with transmitter held busy (first byte parks the FSM in WAIT)
    hold = 1'b1;
    write_byte(8'hA0);
    repeat (5) tick();
    l0 = line.size();
    pulses = 0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      i_wr = 1'b1; i_wr_data = 8'(i);
      tick();
      if (o_overflow) pulses++;
    end
    i_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_overflow) pulses++;
    end
    check("t3_full", 32'(o_full), 1);
    check("t3_count", 32'(o_count), DEPTH);
    check("t3_overflow_pulses", pulses, 2);
    hold = 1'b0;
    wait_idle(peak);
    check("t3_frames", line.size() - l0, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (l0 + i < line.size()) check("t3_frame", 32'(line[l0+i]), 32'(i + 1));

    // 4: dead transmitter, watchdog retry
    dead = 1'b1;
    l0 = line.size();
    write_byte(8'h5A);
    n = 0;
    while (!o_tx_we && n < 10) begin tick(); n++; end
    check("t4_we_rise", 32'(o_tx_we), 1);
    run = 0;
    while (o_tx_we && run < 2000) begin run++; tick(); end
    check("t4_we_high_cycles", run, TO);
    check("t4_count_kept", 32'(o_count), 1);
    check("t4_idle_after_to", 32'(o_active), 0);
    n = 0;
    while (!o_tx_we && n < 10) begin tick(); n++; end
    check("t4_retry", 32'(o_tx_we), 1);
    check("t4_retry_data", 32'(o_tx_data), 32'h5A);
    dead = 1'b0;
    wait_idle(peak);
    check("t4_frames", line.size() - l0, 1);
    if (line.size() > l0) check("t4_frame", 32'(line[l0]), 32'h5A);

    // 5: reset during WAIT with 5 bytes queued
    for (int i = 0; i < 6; i++) write_byte(8'h30 + 8'(i));
    n = 0;
    while (!(o_tx_we && tx_busy && o_count == 5) && n < 30) begin tick(); n++; end
    check("t5_in_wait", 32'(o_count), 5);
    #2 i_rst = 1'b1;
    #1;
    check("t5_async_we", 32'(o_tx_we), 0);
    check("t5_async_empty", 32'(o_empty), 1);
    check("t5_async_count", 32'(o_count), 0);
    tick();
    i_rst = 1'b0;
    l0 = line.size();
    repeat (40) tick();
    check("t5_no_frame", line.size() - l0, 0);
    check("t5_still_empty", 32'(o_empty), 1);

    // 6: write coinciding with the pop that empties the FIFO
    write_byte(8'h70);
    n = 0;
    while (!(o_tx_we && tx_busy && o_count == 1) && n < 20) begin tick(); n++; end
    check("t6_pop_cycle", 32'(o_tx_we && tx_busy), 1);
    l0 = line.size();
    write_byte(8'h71);
    check("t6_retained", 32'(o_count), 1);
    wait_idle(peak);
    check("t6_frames", line.size() - l0, 1);
    if (line.size() > l0) check("t6_next_frame", 32'(line[l0]), 32'h71);

    // Random traffic
    l0 = line.size();
    p0 = n_pops;
    ovf_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      i_wr = ($urandom_range(0, 3) == 0);
      i_wr_data = 8'($urandom);
      tick();
      if (o_overflow) ovf_cnt++;
    end
    i_wr = 1'b0;
    wait_idle(peak);
    check("rand_frames_vs_pops", line.size() - l0, n_pops - p0);
    check("rand_drained", 32'(o_empty), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
